// File: rtl/ram_1port_bist.sv
// Built-in self test for a single-port RAM: writes a pattern to every word, reads it back, counts mismatches.
// Run length 2N+4+RD_LATENCY cycles from start to the cycle after done; start is ignored while busy.
module ram_1port_bist #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic                     ram_wr_en,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              mode_q;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [1:0]              drain_cnt;
  logic                    accept;
  logic                    rd_issue;
  logic                    mismatch;
  logic [DATA_WIDTH-1:0]   exp_word;

  logic [RD_LATENCY-1:0]   pipe_vld;
  logic [DATA_WIDTH-1:0]   pipe_exp  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_addr [RD_LATENCY];

  // Mode 3 inverts within the address width before zero-extending, so the top address maps to 0.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] a_ext;
    logic [DATA_WIDTH-1:0] inv_ext;
    logic [DATA_WIDTH-1:0] ckb;
    logic [ADDR_WIDTH-1:0] a_inv;
    a_inv   = ~a;
    a_ext   = DATA_WIDTH'(a);
    inv_ext = DATA_WIDTH'(a_inv);
    ckb     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ckb[i] = (i % 2 == 1) ? a[0] : ~a[0];
    end
    case (m)
      2'd0:    pattern = '1 - a_ext;
      2'd1:    pattern = a_ext;
      2'd2:    pattern = ckb;
      default: pattern = inv_ext;
    endcase
  endfunction

  assign accept   = (state == S_IDLE) && start;
  assign exp_word = pattern(mode_q, addr_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b1;
    done        = 1'b0;
    ram_wr_en   = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    rd_issue    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        ram_wr_en   = 1'b1;
        ram_addr    = addr_cnt;
        ram_wr_data = exp_word;
        if (&addr_cnt) state_nxt = S_GAP;
      end
      S_GAP: begin
        state_nxt = S_READ;
      end
      S_READ: begin
        ram_addr = addr_cnt;
        rd_issue = 1'b1;
        if (&addr_cnt) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == 2'(RD_LATENCY)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The address counter wraps to zero at the end of each sweep, leaving it ready for the next phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      drain_cnt <= '0;
      mode_q    <= '0;
    end else begin
      if (accept) mode_q <= mode;
      if (state == S_WRITE || state == S_READ) begin
        addr_cnt <= addr_cnt + 1'b1;
      end else begin
        addr_cnt <= '0;
      end
      if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + 2'd1;
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_exp[i]  <= '0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_issue;
      pipe_exp[0]  <= exp_word;
      pipe_addr[0] <= addr_cnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign mismatch = pipe_vld[RD_LATENCY-1] && (ram_rd_data != pipe_exp[RD_LATENCY-1]);

  // A non-zero count means a mismatch was already seen this run, since the counter never wraps back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) first_err_addr <= pipe_addr[RD_LATENCY-1];
      end
      if (state == S_DRAIN && state_nxt == S_DONE) begin
        pass <= (err_cnt == '0);
      end
    end
  end

endmodule
